fir_host: RTL and testbench

AXI initiator that drives one `fir` engine end to end: it programs the engine over AXI-Lite, streams x[n] to it over AXI-Stream, and collects y[n]. It also polls `ap_done` to detect completion. It sits between a local sample/coefficient source and the FIR slave ports, and replaces hand-written bench sequencing in system builds.

---
 rtl/fir_host.sv | 221 ++++++++++++++++++++++
 tb/tb_fir_host.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_host.sv
// rtl/fir_host.sv - AXI initiator that programs, streams and polls one fir engine
// Sequences config writes, x/y stream forwarding and ap_done polling for one job at a time.
module fir_host #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   start,
    input  logic [pDATA_WIDTH-1:0] cfg_len,
    input  logic [pDATA_WIDTH-1:0] cfg_taps,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic                   coef_valid,
    output logic                   coef_ready,
    input  logic [pDATA_WIDTH-1:0] coef_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [pDATA_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [pDATA_WIDTH-1:0] out_data,
    output logic                   out_last,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   ss_tvalid,
    input  logic                   ss_tready,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   sm_tvalid,
    output logic                   sm_tready,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast
);
    typedef enum logic [3:0] {
        S_IDLE, S_WR_LEN, S_WR_TAPS, S_WR_COEF, S_WR_START,
        S_STREAM, S_POLL_AR, S_POLL_R, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_WAIT, PH_AW, PH_W} phase_t;

    localparam logic [pDATA_WIDTH-1:0] ONE        = pDATA_WIDTH'(1);
    localparam logic [pDATA_WIDTH-1:0] TAPS_MAX   = pDATA_WIDTH'(Tape_Num);
    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL  = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN   = pADDR_WIDTH'('h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAPS  = pADDR_WIDTH'('h14);
    localparam logic [pADDR_WIDTH-1:0] ADDR_COEF  = pADDR_WIDTH'('h80);

    state_t                 state_q;
    phase_t                 phase_q;
    logic [pDATA_WIDTH-1:0] len_q, taps_q, idx_q, sent_q, rcvd_q;
    logic                   busy_q, done_q, err_q;
    logic                   awvalid_q, wvalid_q, arvalid_q, rready_q;
    logic [pADDR_WIDTH-1:0] awaddr_q;
    logic [pDATA_WIDTH-1:0] wdata_q;

    logic                   x_open, y_open, ss_fire, sm_fire, cfg_bad;
    logic [pADDR_WIDTH-1:0] coef_addr_d;

    // Stream paths are pure gating so the FIR sees zero added latency.
    assign x_open    = (state_q == S_STREAM) && (sent_q < len_q);
    assign y_open    = (state_q == S_STREAM) && (rcvd_q < len_q);
    assign ss_tvalid = x_open && in_valid;
    assign in_ready  = x_open && ss_tready;
    assign ss_tdata  = in_data;
    assign ss_tlast  = x_open && (sent_q == len_q - ONE);
    assign out_valid = y_open && sm_tvalid;
    assign sm_tready = y_open && out_ready;
    assign out_data  = sm_tdata;
    assign out_last  = y_open && (rcvd_q == len_q - ONE);
    assign ss_fire   = ss_tvalid && ss_tready;
    assign sm_fire   = out_valid && out_ready;

    assign cfg_bad     = (cfg_len == '0) || (cfg_taps == '0) || (cfg_taps > TAPS_MAX);
    assign coef_addr_d = ADDR_COEF + pADDR_WIDTH'(idx_q << 2);
    assign coef_ready  = (state_q == S_WR_COEF) && wvalid_q && wready;

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign awvalid = awvalid_q;
    assign awaddr  = awaddr_q;
    assign wvalid  = wvalid_q;
    assign wdata   = wdata_q;
    assign arvalid = arvalid_q;
    assign araddr  = ADDR_CTRL;
    assign rready  = rready_q;

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_WAIT;
            len_q     <= '0;
            taps_q    <= '0;
            idx_q     <= '0;
            sent_q    <= '0;
            rcvd_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ss_fire) sent_q <= sent_q + ONE;
            if (sm_fire) begin
                rcvd_q <= rcvd_q + ONE;
                if (sm_tlast && (rcvd_q != len_q - ONE)) err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            len_q     <= cfg_len;
                            taps_q    <= cfg_taps;
                            idx_q     <= '0;
                            sent_q    <= '0;
                            rcvd_q    <= '0;
                            err_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            awvalid_q <= 1'b1;
                            awaddr_q  <= ADDR_LEN;
                            wdata_q   <= cfg_len;
                            phase_q   <= PH_AW;
                            state_q   <= S_WR_LEN;
                        end
                    end
                end
                S_WR_LEN, S_WR_TAPS, S_WR_COEF, S_WR_START: begin
                    // PH_WAIT only occurs in WR_COEF, holding off AW until a coefficient is offered.
                    if (phase_q == PH_WAIT) begin
                        if (coef_valid) begin
                            awvalid_q <= 1'b1;
                            awaddr_q  <= coef_addr_d;
                            wdata_q   <= coef_data;
                            phase_q   <= PH_AW;
                        end
                    end else if (phase_q == PH_AW) begin
                        if (awready) begin
                            awvalid_q <= 1'b0;
                            wvalid_q  <= 1'b1;
                            phase_q   <= PH_W;
                        end
                    end else if (wready) begin
                        wvalid_q <= 1'b0;
                        phase_q  <= PH_WAIT;
                        case (state_q)
                            S_WR_LEN: begin
                                state_q   <= S_WR_TAPS;
                                awvalid_q <= 1'b1;
                                awaddr_q  <= ADDR_TAPS;
                                wdata_q   <= taps_q;
                                phase_q   <= PH_AW;
                            end
                            S_WR_TAPS: state_q <= S_WR_COEF;
                            S_WR_COEF: begin
                                if (idx_q == taps_q - ONE) begin
                                    state_q   <= S_WR_START;
                                    awvalid_q <= 1'b1;
                                    awaddr_q  <= ADDR_CTRL;
                                    wdata_q   <= ONE;
                                    phase_q   <= PH_AW;
                                end else begin
                                    idx_q <= idx_q + ONE;
                                end
                            end
                            S_WR_START: state_q <= S_STREAM;
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_STREAM: begin
                    if ((sent_q == len_q) && (rcvd_q == len_q)) begin
                        state_q   <= S_POLL_AR;
                        arvalid_q <= 1'b1;
                    end
                end
                S_POLL_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_POLL_R;
                    end
                end
                S_POLL_R: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        if (rdata[1]) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= S_POLL_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_host.sv
// tb/tb_fir_host.sv - self-checking bench for fir_host
// Bench plays AXI-Lite slave, FIR stream endpoints and sample/coefficient source.
module tb_fir_host;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic          axis_clk = 1'b0;
    logic          axis_rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] cfg_len = '0, cfg_taps = '0;
    logic          busy, done, err;
    logic          coef_valid = 1'b0, coef_ready;
    logic [DW-1:0] coef_data = '0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid, out_ready = 1'b0, out_last;
    logic [DW-1:0] out_data;
    logic          awvalid, awready = 1'b0;
    logic [AW-1:0] awaddr;
    logic          wvalid, wready = 1'b0;
    logic [DW-1:0] wdata;
    logic          arvalid, arready = 1'b0;
    logic [AW-1:0] araddr;
    logic          rvalid = 1'b0, rready;
    logic [DW-1:0] rdata = '0;
    logic          ss_tvalid, ss_tready = 1'b0, ss_tlast;
    logic [DW-1:0] ss_tdata;
    logic          sm_tvalid = 1'b0, sm_tready, sm_tlast = 1'b0;
    logic [DW-1:0] sm_tdata = '0;

    fir_host #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .start(start),
        .cfg_len(cfg_len), .cfg_taps(cfg_taps), .busy(busy), .done(done), .err(err),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    always #5 axis_clk = ~axis_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Job model: coefficients, samples, reference convolution and expected AXI writes
    int            job_len = 0, job_taps = 0, poll_busy_n = 0, early_last = -1;
    int            aw_dly = 0, w_dly = 0;
    bit            bp = 1'b0;
    logic [31:0]   h [16];
    logic [31:0]   x_all [16];
    logic [31:0]   y_exp [16];
    logic [AW-1:0] exp_addr [$];
    logic [31:0]   exp_data [$];

    task automatic setup_job(input int len, input int taps, input int pbusy, input int early,
                             input int awd, input int wd, input bit bpm);
        job_len = len; job_taps = taps; poll_busy_n = pbusy; early_last = early;
        aw_dly = awd; w_dly = wd; bp = bpm;
        for (int i = 0; i < 16; i++) begin
            h[i] = 32'(i + 1);
            x_all[i] = 32'(i + 1);
        end
        for (int n = 0; n < 16; n++) begin
            y_exp[n] = 0;
            for (int k = 0; k < taps && k <= n && k < 16; k++) y_exp[n] += h[k] * x_all[n-k];
        end
        exp_addr.delete(); exp_data.delete();
        exp_addr.push_back(12'h010); exp_data.push_back(32'(len));
        exp_addr.push_back(12'h014); exp_data.push_back(32'(taps));
        for (int i = 0; i < taps && i < 16; i++) begin
            exp_addr.push_back(12'(32'h80 + 4 * i));
            exp_data.push_back(h[i]);
        end
        exp_addr.push_back(12'h000); exp_data.push_back(32'h1);
    endtask

    // Responder: AXI-Lite slave, FIR stream endpoints, coefficient/sample source, sink
    int x_o = 0, c_o = 0, y_o = 0, y_avail = 0, poll_i = 0;
    initial begin : responder
        bit aw_hs, w_hs, ar_hs, r_hs, ss_hs, sm_hs, in_hs, cf_hs;
        int aw_c, w_c;
        aw_c = 0; w_c = 0;
        forever begin
            @(negedge axis_clk);
            aw_hs = awvalid && awready;  w_hs = wvalid && wready;
            ar_hs = arvalid && arready;  r_hs = rvalid && rready;
            ss_hs = ss_tvalid && ss_tready; sm_hs = sm_tvalid && sm_tready;
            in_hs = in_valid && in_ready;   cf_hs = coef_ready;
            @(posedge axis_clk); #1;
            if (axis_rst) begin
                awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = 0;
                ss_tready = 0; out_ready = 0; sm_tvalid = 0; sm_tlast = 0;
                in_valid = 0; coef_valid = 0;
                x_o = 0; c_o = 0; y_o = 0; y_avail = 0; poll_i = 0; aw_c = 0; w_c = 0;
            end else begin
                if (!awvalid || aw_hs) begin awready = 0; aw_c = 0; end
                else if (!awready) begin if (aw_c >= aw_dly) awready = 1; else aw_c++; end
                if (!wvalid || w_hs) begin wready = 0; w_c = 0; end
                else if (!wready) begin if (w_c >= w_dly) wready = 1; else w_c++; end
                arready = arvalid && !ar_hs;
                if (r_hs) begin rvalid = 0; poll_i++; end
                if (ar_hs) begin rvalid = 1; rdata = (poll_i >= poll_busy_n) ? 32'h2 : 32'h0; end
                ss_tready = 1;
                out_ready = bp ? !out_ready : 1'b1;
                if (ss_hs) y_avail++;
                if (sm_hs) y_o++;
                sm_tvalid = y_o < y_avail;
                sm_tdata  = y_exp[y_o % 16];
                sm_tlast  = sm_tvalid && ((early_last >= 0) ? (y_o == early_last) : (y_o == job_len - 1));
                if (in_hs) x_o++;
                in_valid = x_o < job_len;
                in_data  = x_all[x_o % 16];
                if (cf_hs) c_o++;
                coef_valid = c_o < job_taps;
                coef_data  = h[c_o % 16];
            end
        end
    end

    // Compare process: every handshake and pulse against the job model
    int            aw_i = 0, w_i = 0, ss_i = 0, out_i = 0, ar_cnt = 0, done_cnt = 0;
    bit            any_valid = 0, err_at_done = 0, pend_done = 0, prev_aw_wait = 0, prev_w_wait = 0;
    logic [AW-1:0] prev_awaddr = '0;
    logic [31:0]   prev_wdata = '0;
    always @(negedge axis_clk) begin
        if (axis_rst) begin
            aw_i = 0; w_i = 0; ss_i = 0; out_i = 0; ar_cnt = 0;
            any_valid = 0; pend_done = 0; prev_aw_wait = 0; prev_w_wait = 0;
        end else begin
            if (awvalid && wvalid) chk("aw_w_exclusive", 1, 0);
            if (prev_aw_wait) chk("aw_hold", {awvalid, awaddr}, {1'b1, prev_awaddr});
            if (prev_w_wait) chk("w_hold", wvalid ? wdata : ~prev_wdata, prev_wdata);
            if (awvalid && awready) begin
                if (aw_i < exp_addr.size()) chk("awaddr", awaddr, exp_addr[aw_i]);
                else chk("aw_extra", 1, 0);
                aw_i++;
            end
            if (wvalid && wready) begin
                if (w_i < exp_data.size()) chk("wdata", wdata, exp_data[w_i]);
                else chk("w_extra", 1, 0);
                w_i++;
            end
            if (ss_tvalid && ss_tready) begin
                chk("ss_tdata", ss_tdata, x_all[ss_i % 16]);
                chk("ss_tlast", ss_tlast, ss_i == job_len - 1);
                ss_i++;
            end
            if (out_valid && out_ready) begin
                chk("out_data", out_data, y_exp[out_i % 16]);
                chk("out_last", out_last, out_i == job_len - 1);
                out_i++;
            end
            if (arvalid && arready) begin
                chk("araddr", araddr, 0);
                ar_cnt++;
            end
            if (done || pend_done) begin
                chk("done_timing", done, pend_done);
                if (done) begin
                    chk("busy_at_done", busy, 0);
                    done_cnt++;
                    err_at_done = err;
                end
            end
            pend_done = (rvalid && rready && rdata[1]) ||
                        (start && !busy && (cfg_len == 0 || cfg_taps == 0 || cfg_taps > NT));
            any_valid = any_valid | awvalid | wvalid | arvalid | rready | ss_tvalid |
                        in_ready | out_valid | sm_tready | coef_ready;
            prev_aw_wait = awvalid && !awready; prev_awaddr = awaddr;
            prev_w_wait  = wvalid && !wready;   prev_wdata  = wdata;
        end
    end

    task automatic do_reset();
        axis_rst = 1'b1;
        repeat (3) @(posedge axis_clk);
        #3 axis_rst = 1'b0;
    endtask

    task automatic start_job(input int len, input int taps);
        @(posedge axis_clk); #1;
        cfg_len = 32'(len); cfg_taps = 32'(taps); start = 1'b1;
        @(posedge axis_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int d0, n;
        d0 = done_cnt; n = 0;
        while (done_cnt == d0 && n < 3000) begin @(posedge axis_clk); n++; end
        chk(nm, done_cnt != d0, 1);
        repeat (2) @(posedge axis_clk);
        #1;
    endtask

    task automatic job_totals(input string nm, input int nwr, input int nx, input int nar);
        chk({nm, "_aw_count"}, aw_i, nwr);
        chk({nm, "_w_count"}, w_i, nwr);
        chk({nm, "_ss_count"}, ss_i, nx);
        chk({nm, "_out_count"}, out_i, nx);
        chk({nm, "_ar_count"}, ar_cnt, nar);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        axis_rst = 1'b1;
        #23;
        chk("rst_ctrl", {busy, done, err}, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, rready, ss_tvalid, ss_tlast,
                           in_ready, coef_ready, out_valid, out_last, sm_tready}, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_araddr", araddr, 0);
        do_reset();

        // Happy path
        setup_job(4, 11, 0, -1, 0, 0, 1'b0);
        chk("model_y0", y_exp[0], 1);
        chk("model_y1", y_exp[1], 4);
        chk("model_y2", y_exp[2], 10);
        chk("model_y3", y_exp[3], 20);
        chk("model_coef_last_addr", exp_addr[12], 12'h0A8);
        chk("model_wr_count", exp_addr.size(), 14);
        start_job(4, 11);
        chk("start_busy", busy, 1);
        chk("start_aw", {awvalid, awaddr}, {1'b1, 12'h010});
        wait_done("happy_done");
        job_totals("happy", 14, 4, 1);
        chk("happy_err", err_at_done, 0);

        // Back-pressure, plus a start pulse while busy that must be ignored
        do_reset();
        setup_job(4, 11, 0, -1, 3, 3, 1'b1);
        start_job(4, 11);
        repeat (8) @(posedge axis_clk);
        #1 cfg_len = 7; start = 1'b1;
        @(posedge axis_clk); #1 start = 1'b0;
        wait_done("bp_done");
        job_totals("bp", 14, 4, 1);
        chk("bp_err", err_at_done, 0);

        // Bad config, then an accepted start must clear err
        do_reset();
        setup_job(4, 12, 0, -1, 0, 0, 1'b0);
        start_job(4, 12);
        chk("bad_done_err_busy", {done, err, busy}, 3'b110);
        repeat (3) @(posedge axis_clk);
        #1;
        chk("bad_after", {done, err}, 2'b01);
        chk("bad_no_traffic", any_valid, 0);

        // Early sm_tlast on y #2
        setup_job(4, 11, 0, 1, 0, 0, 1'b0);
        start_job(4, 11);
        chk("accept_clears_err", {busy, err}, 2'b10);
        wait_done("early_done");
        job_totals("early", 14, 4, 1);
        chk("early_err", err_at_done, 1);

        // Polling: three not-done reads before ap_done, different len/taps
        do_reset();
        setup_job(3, 2, 3, -1, 0, 0, 1'b0);
        chk("model_poll_y2", y_exp[2], 7);
        start_job(3, 2);
        wait_done("poll_done");
        job_totals("poll", 5, 3, 4);

        // Reset during WR_COEF at i=5, then a full rerun
        do_reset();
        setup_job(4, 11, 0, -1, 1, 1, 1'b0);
        start_job(4, 11);
        begin
            int n;
            n = 0;
            while (!(awvalid && awaddr == 12'h094) && n < 300) begin @(negedge axis_clk); n++; end
            chk("reach_coef5", n < 300, 1);
        end
        #1 axis_rst = 1'b1;
        #1;
        chk("midrst_valids", {awvalid, wvalid, arvalid, rready, ss_tvalid, in_ready,
                              coef_ready, out_valid, sm_tready, busy, done, err}, 0);
        chk("midrst_bus", {awaddr, wdata}, 0);
        repeat (2) @(posedge axis_clk);
        #3 axis_rst = 1'b0;
        setup_job(4, 11, 0, -1, 0, 0, 1'b0);
        start_job(4, 11);
        chk("rerun_aw", {awvalid, awaddr}, {1'b1, 12'h010});
        wait_done("rerun_done");
        job_totals("rerun", 14, 4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
